// File: rtl/acq_serial_tx.sv
// Scans a multiplexed ADC channel by channel and sends each latched sample as an
// asynchronous frame: start bit, data MSB-first, optional even parity, stop bit.
//
// state    | meaning
// A_MUX    | enable analog mux for current channel
// A_SETTLE | one cycle of mux settling
// A_SOC    | raise start-of-conversion
// A_WAIT   | wait for eoc low, latch sample
// A_ADV    | drop soc/strobe, advance channel
// A_SEND   | start frame if partner ready, else flag error
// A_TXW    | wait for frame completion
module acq_serial_tx #(
  parameter int DATA_W    = 8,
  parameter int NUM_CH    = 8,
  parameter int CH_W      = 4,
  parameter int BAUD_DIV  = 104,
  parameter int PARITY_EN = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              eoc,
  input  logic [DATA_W-1:0] data_in,
  input  logic              dsr,
  output logic              mux_en,
  output logic              soc,
  output logic              load_dato,
  output logic [CH_W-1:0]   canale,
  output logic              data_out,
  output logic              error,
  output logic              busy,
  output logic              tx_done
);

  localparam int NBITS = DATA_W + 2 + PARITY_EN;
  localparam int CNT_W = (BAUD_DIV < 1) ? 1 : $clog2(BAUD_DIV + 1);
  localparam int IDX_W = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BAUD_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBITS - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    A_MUX, A_SETTLE, A_SOC, A_WAIT, A_ADV, A_SEND, A_TXW
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  out_reg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [IDX_W-1:0]   bit_idx;
  logic [NBITS-1:0]   shift_reg;
  logic [NBITS-1:0]   frame_vec;

  // Whole frame, first bit on the line at the MSB end.
  always_comb begin
    frame_vec = '1;
    frame_vec[NBITS-1] = 1'b0;
    frame_vec[NBITS-2 -: DATA_W] = out_reg;
    if (PARITY_EN != 0) frame_vec[1] = ^out_reg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= A_MUX;
      mux_en    <= 1'b0;
      soc       <= 1'b0;
      load_dato <= 1'b0;
      canale    <= '0;
      data_out  <= 1'b1;
      error     <= 1'b0;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
      out_reg   <= '0;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      tx_done <= 1'b0;

      if (busy) begin
        if (bit_cnt == CNT_MAX) begin
          bit_cnt <= '0;
          if (bit_idx == IDX_LAST) begin
            busy     <= 1'b0;
            tx_done  <= 1'b1;
            data_out <= 1'b1;
          end else begin
            bit_idx   <= bit_idx + 1'b1;
            data_out  <= shift_reg[NBITS-1];
            shift_reg <= {shift_reg[NBITS-2:0], 1'b1};
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      case (state)
        A_MUX: begin
          mux_en <= 1'b1;
          state  <= A_SETTLE;
        end
        A_SETTLE: state <= A_SOC;
        A_SOC: begin
          soc   <= 1'b1;
          state <= A_WAIT;
        end
        A_WAIT: begin
          if (!eoc) begin
            load_dato <= 1'b1;
            out_reg   <= data_in;
            mux_en    <= 1'b0;
            state     <= A_ADV;
          end
        end
        A_ADV: begin
          load_dato <= 1'b0;
          soc       <= 1'b0;
          canale    <= (canale == CH_LAST) ? '0 : canale + 1'b1;
          state     <= A_SEND;
        end
        A_SEND: begin
          if (dsr) begin
            error     <= 1'b0;
            busy      <= 1'b1;
            data_out  <= 1'b0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= {frame_vec[NBITS-2:0], 1'b1};
            state     <= A_TXW;
          end else begin
            error <= 1'b1;
            state <= A_MUX;
          end
        end
        A_TXW: if (tx_done) state <= A_MUX;
        default: state <= A_MUX;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_serial_tx.sv
// Randomized bench for acq_serial_tx; frames are compared against a bit-position
// model of the line format, channel order against a modulo counter.
module tb_acq_serial_tx;
  localparam int DATA_W    = 8;
  localparam int NUM_CH    = 3;
  localparam int CH_W      = 2;
  localparam int BAUD_DIV  = 3;
  localparam int PARITY_EN = 1;
  localparam int BIT_T     = BAUD_DIV + 1;
  localparam int NBITS     = DATA_W + 2 + PARITY_EN;
  localparam int FRAME_LEN = NBITS * BIT_T;

  localparam int W_SOC = 0, W_LOAD = 1, W_BUSY = 2, W_TXDONE = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              eoc = 1'b1;
  logic              dsr = 1'b1;
  logic [DATA_W-1:0] data_in = '0;
  logic              mux_en, soc, load_dato, data_out, error, busy, tx_done;
  logic [CH_W-1:0]   canale;

  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_ch = 0;
  bit   mon_on = 1'b0;
  logic prev_tx_done = 1'b0;

  acq_serial_tx #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W),
    .BAUD_DIV(BAUD_DIV), .PARITY_EN(PARITY_EN)
  ) dut (
    .clock(clock), .reset(reset), .eoc(eoc), .data_in(data_in), .dsr(dsr),
    .mux_en(mux_en), .soc(soc), .load_dato(load_dato), .canale(canale),
    .data_out(data_out), .error(error), .busy(busy), .tx_done(tx_done)
  );

  always #5 clock = ~clock;

  // Line value at frame position p (0 = start bit).
  function automatic logic frame_bit(input logic [DATA_W-1:0] d, input int p);
    if (p == 0) return 1'b0;
    if (p <= DATA_W) return d[DATA_W-p];
    if (PARITY_EN != 0 && p == DATA_W + 1) return logic'(($countones(d) % 2) == 1);
    return 1'b1;
  endfunction

  always @(negedge clock) begin
    if (mon_on) begin
      n_checks++;
      if ((load_dato && !soc) || (prev_tx_done && busy) || (error && busy) ||
          (int'(canale) >= NUM_CH) || (!busy && !data_out))
        $display("FAIL invariant: load_dato=%b soc=%b prev_tx_done=%b busy=%b error=%b canale=%0d data_out=%b",
                 load_dato, soc, prev_tx_done, busy, error, canale, data_out);
      else n_pass++;
    end
    prev_tx_done = tx_done;
  end

  task automatic wait_for(input int which, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      case (which)
        W_SOC:    ok = soc;
        W_LOAD:   ok = load_dato;
        W_BUSY:   ok = busy;
        W_TXDONE: ok = tx_done;
        default:  ok = 1'b0;
      endcase
      if (ok) break;
    end
  endtask

  // Answers one conversion; returns at the negedge where load_dato is seen.
  task automatic acquire(input logic [DATA_W-1:0] d, input int dly, input logic dsr_v,
                         output bit ok, output int ch_at_load);
    bit got;
    dsr = dsr_v;
    ch_at_load = -1;
    wait_for(W_SOC, 200, got);
    if (!got) begin ok = 1'b0; return; end
    repeat (dly) @(negedge clock);
    eoc = 1'b0;
    data_in = d;
    wait_for(W_LOAD, 20, got);
    ch_at_load = int'(canale);
    eoc = 1'b1;
    data_in = DATA_W'($urandom);
    ok = got;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    mon_on = 1'b1;
    n_checks++;
    if (mux_en !== 1'b0 || soc !== 1'b0 || load_dato !== 1'b0 || canale !== '0)
      $display("FAIL reset_acq: mux_en=%b soc=%b load_dato=%b canale=%0d required 0,0,0,0",
               mux_en, soc, load_dato, canale);
    else n_pass++;
    n_checks++;
    if (data_out !== 1'b1 || error !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0)
      $display("FAIL reset_tx: data_out=%b error=%b busy=%b tx_done=%b required 1,0,0,0",
               data_out, error, busy, tx_done);
    else n_pass++;
    reset = 1'b0;
    exp_ch = 0;
    @(negedge clock);
    n_checks++;
    if (mux_en !== 1'b1 || soc !== 1'b0)
      $display("FAIL reset_first_mux: mux_en=%b soc=%b required 1,0", mux_en, soc);
    else n_pass++;
    repeat (2) @(negedge clock);
    n_checks++;
    if (soc !== 1'b1) $display("FAIL reset_soc_latency: soc=%b required 1", soc);
    else n_pass++;
  endtask

  // Seven accepted frames from channel 0: covers wrap (1,2,0,1,2,0,1) and parity.
  task automatic test_frames();
    logic [DATA_W-1:0] d;
    bit ok;
    int ch, bad_k;
    for (int f = 0; f < 7; f++) begin
      d = (f == 0) ? 8'h07 : (f == 1) ? 8'hA5 : DATA_W'($urandom);
      acquire(d, $urandom_range(0, 5), 1'b1, ok, ch);
      n_checks++;
      if (!ok) begin
        $display("FAIL frame_acquire_timeout: frame=%0d ok=%0d required 1", f, ok);
        continue;
      end
      n_pass++;
      n_checks++;
      if (ch !== exp_ch) $display("FAIL frame_sample_channel: canale=%0d required %0d", ch, exp_ch);
      else n_pass++;
      exp_ch = (exp_ch + 1) % NUM_CH;
      @(negedge clock);
      n_checks++;
      if (int'(canale) !== exp_ch) $display("FAIL frame_canale_adv: canale=%0d required %0d", canale, exp_ch);
      else n_pass++;
      @(negedge clock);
      bad_k = -1;
      for (int k = 0; k < FRAME_LEN; k++) begin
        if (bad_k < 0 && (busy !== 1'b1 || data_out !== frame_bit(d, k / BIT_T))) bad_k = k;
        @(negedge clock);
      end
      n_checks++;
      if (bad_k >= 0)
        $display("FAIL frame_bits: data=%h first bad cycle=%0d required none (bit pos %0d expected %b)",
                 d, bad_k, bad_k / BIT_T, frame_bit(d, bad_k / BIT_T));
      else n_pass++;
      n_checks++;
      if (tx_done !== 1'b1 || busy !== 1'b0 || data_out !== 1'b1)
        $display("FAIL frame_end: tx_done=%b busy=%b data_out=%b required 1,0,1", tx_done, busy, data_out);
      else n_pass++;
      @(negedge clock);
      n_checks++;
      if (tx_done !== 1'b0) $display("FAIL frame_done_pulse: tx_done=%b required 0", tx_done);
      else n_pass++;
    end
  endtask

  task automatic test_dsr_refuse();
    bit ok, idle_ok;
    int ch, cyc;
    for (int r = 0; r < 2; r++) begin
      acquire(DATA_W'($urandom), $urandom_range(0, 3), 1'b0, ok, ch);
      n_checks++;
      if (!ok || ch !== exp_ch)
        $display("FAIL refuse_acquire: ok=%0d canale=%0d required 1,%0d", ok, ch, exp_ch);
      else n_pass++;
      if (r == 1) begin
        n_checks++;
        if (error !== 1'b1) $display("FAIL refuse_sticky: error=%b required 1", error);
        else n_pass++;
      end
      exp_ch = (exp_ch + 1) % NUM_CH;
      repeat (2) @(negedge clock);
      n_checks++;
      if (error !== 1'b1 || busy !== 1'b0 || data_out !== 1'b1)
        $display("FAIL refuse_flag: error=%b busy=%b data_out=%b required 1,0,1", error, busy, data_out);
      else n_pass++;
      idle_ok = 1'b1;
      cyc = 0;
      while (soc !== 1'b1 && cyc < 20) begin
        if (tx_done !== 1'b0 || data_out !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
        @(negedge clock);
        cyc++;
      end
      n_checks++;
      if (!idle_ok || soc !== 1'b1)
        $display("FAIL refuse_idle: idle_ok=%0d soc=%b required 1,1", idle_ok, soc);
      else n_pass++;
    end
    acquire(DATA_W'($urandom), 0, 1'b1, ok, ch);
    exp_ch = (exp_ch + 1) % NUM_CH;
    n_checks++;
    if (!ok || error !== 1'b1)
      $display("FAIL refuse_hold_until_start: ok=%0d error=%b required 1,1", ok, error);
    else n_pass++;
    repeat (2) @(negedge clock);
    n_checks++;
    if (busy !== 1'b1 || error !== 1'b0)
      $display("FAIL refuse_clear_on_start: busy=%b error=%b required 1,0", busy, error);
    else n_pass++;
    wait_for(W_TXDONE, FRAME_LEN + 10, ok);
    n_checks++;
    if (!ok) $display("FAIL refuse_frame_done_timeout: tx_done=%b required 1", tx_done);
    else n_pass++;
  endtask

  task automatic test_eoc_hold();
    bit ok, hold_ok;
    wait_for(W_SOC, 200, ok);
    dsr = 1'b1;
    hold_ok = ok;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (soc !== 1'b1 || mux_en !== 1'b1 || load_dato !== 1'b0) hold_ok = 1'b0;
    end
    n_checks++;
    if (!hold_ok) $display("FAIL eoc_hold: soc=%b mux_en=%b load_dato=%b required 1,1,0", soc, mux_en, load_dato);
    else n_pass++;
    eoc = 1'b0;
    data_in = DATA_W'($urandom);
    wait_for(W_LOAD, 5, ok);
    eoc = 1'b1;
    n_checks++;
    if (!ok || int'(canale) !== exp_ch)
      $display("FAIL eoc_release_load: load_dato=%b canale=%0d required 1,%0d", load_dato, canale, exp_ch);
    else n_pass++;
    exp_ch = (exp_ch + 1) % NUM_CH;
    @(negedge clock);
    n_checks++;
    if (load_dato !== 1'b0) $display("FAIL eoc_load_pulse_width: load_dato=%b required 0", load_dato);
    else n_pass++;
    wait_for(W_TXDONE, FRAME_LEN + 10, ok);
    n_checks++;
    if (!ok) $display("FAIL eoc_frame_done_timeout: tx_done=%b required 1", tx_done);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    bit ok, quiet;
    int ch;
    acquire(DATA_W'($urandom), 1, 1'b1, ok, ch);
    repeat (2) @(negedge clock);
    // land inside data bit 3 (frame position 5)
    repeat (5 * BIT_T + 1) @(negedge clock);
    n_checks++;
    if (!ok || busy !== 1'b1) $display("FAIL midreset_precond: ok=%0d busy=%b required 1,1", ok, busy);
    else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (data_out !== 1'b1 || busy !== 1'b0 || canale !== '0 || error !== 1'b0 || mux_en !== 1'b0)
      $display("FAIL midreset_state: data_out=%b busy=%b canale=%0d error=%b mux_en=%b required 1,0,0,0,0",
               data_out, busy, canale, error, mux_en);
    else n_pass++;
    reset = 1'b0;
    exp_ch = 0;
    @(negedge clock);
    n_checks++;
    if (mux_en !== 1'b1) $display("FAIL midreset_restart: mux_en=%b required 1", mux_en);
    else n_pass++;
    quiet = 1'b1;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      if (tx_done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      @(negedge clock);
    end
    n_checks++;
    if (!quiet) $display("FAIL midreset_no_tx_done: tx_done=%b busy=%b required 0,0", tx_done, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frames();
    test_dsr_refuse();
    test_eoc_hold();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/acq_serial_tx.md
Name: acq_serial_tx

Overview:
- Parametrised acquisition-and-transmit controller.
- Sequences an external multiplexed ADC over NUM_CH channels, latches each DATA_W-bit sample, and ships it on an asynchronous serial line: start bit, data MSB-first, optional even parity, stop bit.
- Adds three things over the fixed-width 8-channel predecessor: a configurable bit period, a parity mode, and a reset.
- Sits between the analog-front-end mux/ADC and the line driver.

Parameters:
- DATA_W, 8, sample and frame data width (1..16).
- NUM_CH, 8, number of mux channels scanned (2..16).
- CH_W, 4, width of canale; must satisfy 2**CH_W >= NUM_CH.
- BAUD_DIV, 104, bit period is BAUD_DIV+1 clock cycles (1..1023).
- PARITY_EN, 0, 1 = append even-parity bit after data.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- eoc  input  1  ADC end-of-conversion; low = conversion done.
- data_in  input  DATA_W  ADC result, valid while eoc low.
- dsr  input  1  line partner ready; sampled at frame start.
- mux_en  output  1  analog mux enable.
- soc  output  1  ADC start-of-conversion.
- load_dato  output  1  one-cycle sample-latch strobe.
- canale  output  CH_W  selected channel.
- data_out  output  1  serial line; idles high.
- error  output  1  sticky frame-refused flag.
- busy  output  1  high while a frame is on the line.
- tx_done  output  1  one-cycle pulse after stop bit completes.

Behaviour:
- Reset, synchronous, dominates all other activity:
  - state=A_MUX.
  - mux_en=0, soc=0, load_dato=0, canale=0, data_out=1, error=0, busy=0, tx_done=0.
  - Bit counter, bit index and shift register cleared.
- Reset mid-frame: frame is abandoned; data_out=1 on the cycle after reset is sampled. No tx_done.
- Acquisition FSM, one transition per cycle unless stated:
  - A_MUX: mux_en<=1 -> A_SETTLE.
  - A_SETTLE -> A_SOC.
  - A_SOC: soc<=1 -> A_WAIT.
  - A_WAIT: while eoc=1, stay. When eoc=0: load_dato<=1, out_reg<=data_in, mux_en<=0 -> A_ADV.
  - A_ADV: load_dato<=0, soc<=0; canale<=(canale==NUM_CH-1)?0:canale+1 -> A_SEND.
  - A_SEND:
    - If dsr=1: start transmitter, error<=0 -> A_TXW.
    - If dsr=0: error<=1, sample dropped, no frame -> A_MUX.
  - A_TXW: wait for tx_done=1 -> A_MUX.
- The sample sent is the one acquired on the channel before the canale increment.
- Transmitter:
  - On start: busy<=1, data_out<=0 (start bit) on the next cycle.
  - Each bit is held exactly BAUD_DIV+1 cycles. The bit counter counts 0..BAUD_DIV and advances the bit at BAUD_DIV.
  - Bit order: start(0), out_reg[DATA_W-1] .. out_reg[0], parity (XOR of data bits, only if PARITY_EN), stop(1).
  - After the stop period: tx_done=1 for one cycle, busy<=0, data_out stays 1.
  - Frame length = (DATA_W+2+PARITY_EN)*(BAUD_DIV+1) cycles.
- out_reg is not reloaded while busy; the FSM cannot reach A_WAIT while busy.
- error is sticky across dropped samples. It clears only on the next accepted frame start or on reset.
- canale wraps at NUM_CH-1; values >= NUM_CH never appear.
- Invariants (assertion targets):
  - load_dato -> soc.
  - tx_done -> !busy next cycle.
  - error -> !busy.
  - canale < NUM_CH.
  - data_out=1 whenever !busy.

Test Plan:
- Default params, dsr=1, eoc drops 2 cycles after soc, data_in=8'hA5 -> frame on data_out: 0,1,0,1,0,0,1,0,1,1, each bit held 105 cycles. tx_done pulses once; canale 0->1.
- DATA_W=8, BAUD_DIV=3, PARITY_EN=1, data_in=8'h07 -> 11 bits of 4 cycles each, parity bit=1; frame spans 44 cycles.
- NUM_CH=3, run 7 samples -> canale sequence 1,2,0,1,2,0,1; never 3.
- dsr=0 at A_SEND -> error=1, data_out stays 1, no tx_done, next acquisition starts. Next dsr=1 frame clears error at frame start.
- eoc held high 50 cycles -> FSM stays in A_WAIT, soc=1, mux_en=1, load_dato=0 throughout. Release eoc -> load_dato pulses exactly one cycle.
- reset asserted during data bit 3 of a frame -> next cycle: data_out=1, busy=0, canale=0, error=0, mux_en=0. Acquisition restarts from A_MUX with no tx_done.
